// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch path: loader FSM encoding and instruction geometry.
package cpu_pkg;
   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   localparam int INSTR_BYTES = 2;
   localparam int ADDR_W_DEF  = 8;
endpackage

// File: rtl/instruction_memory_if.sv
// Byte-stream program load port: the loader is master, the instruction memory is slave.
interface instruction_memory_if;
   logic       load_valid;
   logic [7:0] load_data;
   logic       load_last;
   logic       load_ready;

   modport master (output load_valid, output load_data, output load_last, input load_ready);
   modport slave  (input load_valid, input load_data, input load_last, output load_ready);
endinterface

// File: rtl/byte_ram.sv
// Byte-wide storage with one synchronous write port and two asynchronous read ports.
module byte_ram #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr_a,
   output logic [DATA_W-1:0] o_rdata_a,
   input  logic [ADDR_W-1:0] i_raddr_b,
   output logic [DATA_W-1:0] o_rdata_b
);
   logic [DATA_W-1:0] r_mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Reads see the pre-write contents when they hit the address being written.
   assign o_rdata_a = r_mem[i_raddr_a];
   assign o_rdata_b = r_mem[i_raddr_b];
endmodule

// File: rtl/instruction_memory.sv
// Program store for the single-cycle CPU: clears itself, loads a byte stream, then serves fetches.
module instruction_memory
   import cpu_pkg::*;
#(
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   instruction_memory_if.slave      ld,
   input  logic [ADDR_W-1:0]        pc,
   output logic [8*INSTR_BYTES-1:0] instr,
   output logic                     misaligned,
   output logic                     cpu_hold
);
   localparam state_t INIT_ST = CLEAR_ON_RESET ? ST_CLEAR : ST_LOAD;

   state_t            r_state;
   state_t            w_next_state;
   logic [ADDR_W-1:0] r_ptr;
   logic              w_ptr_last;
   logic              w_fire;
   logic              w_we;
   logic [7:0]        w_wdata;
   logic [ADDR_W-1:0] w_pc_next;
   logic [7:0]        w_rd_hi;
   logic [7:0]        w_rd_lo;

   assign w_ptr_last = (r_ptr == '1);
   assign w_fire     = (r_state == ST_LOAD) && ld.load_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= INIT_ST;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_CLEAR: if (w_ptr_last) w_next_state = ST_LOAD;
         ST_LOAD:  if (w_fire && (ld.load_last || w_ptr_last)) w_next_state = ST_RUN;
         ST_RUN:   w_next_state = ST_RUN;
         default:  w_next_state = INIT_ST;
      endcase
   end

   // A write coincident with reset is suppressed so a dropped handshake leaves no trace.
   always_comb begin
      w_we          = 1'b0;
      w_wdata       = 8'h00;
      ld.load_ready = 1'b0;
      cpu_hold      = 1'b1;
      case (r_state)
         ST_CLEAR: begin
            w_we = !reset;
         end
         ST_LOAD: begin
            ld.load_ready = 1'b1;
            w_we          = w_fire && !reset;
            w_wdata       = ld.load_data;
         end
         ST_RUN: begin
            cpu_hold = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= '0;
      end else if ((r_state == ST_CLEAR) || w_fire) begin
         r_ptr <= r_ptr + ADDR_W'(1);
      end
   end

   assign w_pc_next  = pc + ADDR_W'(1);
   assign instr      = {w_rd_hi, w_rd_lo};
   assign misaligned = pc[0];

   byte_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (8)
   ) u_ram (
      .clk       (clk),
      .i_we      (w_we),
      .i_waddr   (r_ptr),
      .i_wdata   (w_wdata),
      .i_raddr_a (pc),
      .o_rdata_a (w_rd_hi),
      .i_raddr_b (w_pc_next),
      .o_rdata_b (w_rd_lo)
   );
endmodule
